// File: rtl/trigger_engine_seg_pkg.sv
// Shared types for the segmented trigger engine: run-state encoding and ADC compare modes.
package trigger_engine_seg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_INACT,
        ST_ARMED,
        ST_DELAY,
        ST_CAPTURE,
        ST_HOLDOFF,
        ST_DONE
    } trig_state_t;

    localparam logic [1:0] MODE_ABOVE   = 2'b00;
    localparam logic [1:0] MODE_BELOW   = 2'b01;
    localparam logic [1:0] MODE_INSIDE  = 2'b10;
    localparam logic [1:0] MODE_OUTSIDE = 2'b11;

endpackage

// File: rtl/trigger_engine_seg_if.sv
// Capture handshake between the trigger engine (master) and the sample FIFO writer (slave).
interface trigger_engine_seg_if;

    logic capture_go_o;
    logic segment_go_o;
    logic capture_done_i;

    modport master (output capture_go_o, output segment_go_o, input capture_done_i);
    modport slave  (input capture_go_o, input segment_go_o, output capture_done_i);

endinterface

// File: rtl/trigger_engine_seg_cond.sv
// Trigger condition: windowed ADC compare or masked external combine, polarity applied, registered.
module trigger_engine_seg_cond
    import trigger_engine_seg_pkg::*;
#(
    parameter int ADC_W   = 12,
    parameter int NUM_EXT = 4
) (
    input  logic               adc_clk,
    input  logic               reset,
    input  logic [ADC_W-1:0]   adc_data,
    input  logic [NUM_EXT-1:0] ext_trig_i,
    input  logic [NUM_EXT-1:0] ext_mask_i,
    input  logic               ext_and_i,
    input  logic               source_i,
    input  logic [1:0]         adc_mode_i,
    input  logic [ADC_W-1:0]   level_hi_i,
    input  logic [ADC_W-1:0]   level_lo_i,
    input  logic               polarity_i,
    output logic               o_trig
);

    logic w_above;
    logic w_below;
    logic w_adcCond;
    logic w_extCond;
    logic w_cond;
    logic r_trig;

    always_comb begin
        w_above   = adc_data > level_hi_i;
        w_below   = adc_data < level_lo_i;
        w_adcCond = 1'b0;
        w_extCond = 1'b0;
        case (adc_mode_i)
            MODE_ABOVE:  w_adcCond = w_above;
            MODE_BELOW:  w_adcCond = w_below;
            MODE_INSIDE: w_adcCond = !w_above && !w_below;
            default:     w_adcCond = w_above || w_below;
        endcase
        // With nothing unmasked the external source never fires, even in AND mode.
        if (ext_mask_i != '0) begin
            if (ext_and_i) w_extCond = &(ext_trig_i | ~ext_mask_i);
            else           w_extCond = |(ext_trig_i & ext_mask_i);
        end
        w_cond = source_i ? w_adcCond : w_extCond;
    end

    always_ff @(posedge adc_clk) begin
        if (reset) r_trig <= 1'b0;
        else       r_trig <= polarity_i ? w_cond : ~w_cond;
    end

    assign o_trig = r_trig;

endmodule

// File: rtl/trigger_engine_seg.sv
// Segmented trigger engine: trigger_now sync, run FSM, and offset/holdoff/segment/length counters.
module trigger_engine_seg
    import trigger_engine_seg_pkg::*;
#(
    parameter int ADC_W   = 12,
    parameter int NUM_EXT = 4,
    parameter int OFF_W   = 32,
    parameter int HOLD_W  = 16,
    parameter int SEG_W   = 16,
    parameter int LEN_W   = 32
) (
    input  logic                 adc_clk,
    input  logic                 reset,
    input  logic [ADC_W-1:0]     adc_data,
    input  logic [NUM_EXT-1:0]   ext_trig_i,
    input  logic [NUM_EXT-1:0]   ext_mask_i,
    input  logic                 ext_and_i,
    input  logic                 source_i,
    input  logic [1:0]           adc_mode_i,
    input  logic [ADC_W-1:0]     level_hi_i,
    input  logic [ADC_W-1:0]     level_lo_i,
    input  logic                 polarity_i,
    input  logic                 wait_i,
    input  logic                 trigger_now_i,
    input  logic                 arm_i,
    input  logic [OFF_W-1:0]     offset_i,
    input  logic [HOLD_W-1:0]    holdoff_i,
    input  logic [SEG_W-1:0]     num_segments_i,
    trigger_engine_seg_if.master cap_if,
    output logic                 arm_o,
    output logic [SEG_W-1:0]     seg_count_o,
    output logic [LEN_W-1:0]     trigger_length_o,
    output logic                 done_o
);

    trig_state_t       r_state;
    trig_state_t       w_nextState;
    trig_state_t       w_runEntry;
    trig_state_t       w_trigTarget;
    logic              w_trig;
    logic [2:0]        r_nowSync;
    logic              r_nowP;
    logic              r_armPrev;
    logic              w_armRise;
    logic              r_inCapture;
    logic [OFF_W-1:0]  r_delayCnt;
    logic [HOLD_W-1:0] r_holdCnt;
    logic [SEG_W-1:0]  r_segCount;
    logic [SEG_W-1:0]  w_segInc;
    logic [SEG_W-1:0]  w_segMax;
    logic [LEN_W-1:0]  r_trigLen;

    trigger_engine_seg_cond #(.ADC_W(ADC_W), .NUM_EXT(NUM_EXT)) u_cond (
        .adc_clk    (adc_clk),
        .reset      (reset),
        .adc_data   (adc_data),
        .ext_trig_i (ext_trig_i),
        .ext_mask_i (ext_mask_i),
        .ext_and_i  (ext_and_i),
        .source_i   (source_i),
        .adc_mode_i (adc_mode_i),
        .level_hi_i (level_hi_i),
        .level_lo_i (level_lo_i),
        .polarity_i (polarity_i),
        .o_trig     (w_trig)
    );

    assign w_armRise    = arm_i && !r_armPrev;
    assign w_runEntry   = wait_i ? ST_WAIT_INACT : ST_ARMED;
    // Zero offset skips DELAY so capture starts the cycle after the trigger cycle.
    assign w_trigTarget = (offset_i == '0) ? ST_CAPTURE : ST_DELAY;
    assign w_segMax     = (num_segments_i == '0) ? SEG_W'(1) : num_segments_i;
    assign w_segInc     = (&r_segCount) ? r_segCount : r_segCount + SEG_W'(1);

    always_ff @(posedge adc_clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        if (!arm_i) begin
            w_nextState = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:       if (w_armRise) w_nextState = w_runEntry;
                ST_WAIT_INACT: begin
                    if (r_nowP)       w_nextState = w_trigTarget;
                    else if (!w_trig) w_nextState = ST_ARMED;
                end
                ST_ARMED:      if (w_trig || r_nowP) w_nextState = w_trigTarget;
                ST_DELAY:      if (r_delayCnt == offset_i - OFF_W'(1)) w_nextState = ST_CAPTURE;
                ST_CAPTURE: begin
                    if (cap_if.capture_done_i) begin
                        if (w_segInc >= w_segMax)  w_nextState = ST_DONE;
                        else if (holdoff_i == '0)  w_nextState = w_runEntry;
                        else                       w_nextState = ST_HOLDOFF;
                    end
                end
                ST_HOLDOFF:    if (r_holdCnt == holdoff_i - HOLD_W'(1)) w_nextState = w_runEntry;
                ST_DONE:       w_nextState = ST_DONE;
                default:       w_nextState = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge adc_clk) begin
        if (reset) begin
            r_nowSync   <= '0;
            r_nowP      <= 1'b0;
            r_armPrev   <= 1'b0;
            r_inCapture <= 1'b0;
            r_delayCnt  <= '0;
            r_holdCnt   <= '0;
            r_segCount  <= '0;
            r_trigLen   <= '0;
        end else begin
            r_nowSync   <= {r_nowSync[1:0], trigger_now_i};
            r_nowP      <= r_nowSync[1] && !r_nowSync[2];
            r_armPrev   <= arm_i;
            r_inCapture <= (r_state == ST_CAPTURE);
            r_delayCnt  <= (r_state == ST_DELAY)   ? r_delayCnt + OFF_W'(1)  : '0;
            r_holdCnt   <= (r_state == ST_HOLDOFF) ? r_holdCnt + HOLD_W'(1) : '0;
            // Abort dominates a coincident capture_done.
            if (!arm_i)
                r_segCount <= '0;
            else if (r_state == ST_CAPTURE && cap_if.capture_done_i)
                r_segCount <= w_segInc;
            if (w_armRise)
                r_trigLen <= '0;
            else if (r_state != ST_IDLE && w_trig && !(&r_trigLen))
                r_trigLen <= r_trigLen + LEN_W'(1);
        end
    end

    assign arm_o               = (r_state != ST_IDLE);
    assign done_o              = (r_state == ST_DONE);
    assign cap_if.capture_go_o = (r_state == ST_CAPTURE);
    assign cap_if.segment_go_o = (r_state == ST_CAPTURE) && !r_inCapture;
    assign seg_count_o         = r_segCount;
    assign trigger_length_o    = r_trigLen;

endmodule

// File: tb/tb_trigger_engine_seg.sv
// Directed bench for trigger_engine_seg: ADC/ext trigger paths, offsets, segments, trigger_now, abort.
module tb_trigger_engine_seg;

    logic        adcClk = 1'b0;
    logic        reset;
    logic [11:0] adcData;
    logic [3:0]  extTrig;
    logic [3:0]  extMask;
    logic        extAnd;
    logic        source;
    logic [1:0]  adcMode;
    logic [11:0] levelHi;
    logic [11:0] levelLo;
    logic        polarity;
    logic        waitInact;
    logic        triggerNow;
    logic        arm;
    logic [31:0] offset;
    logic [15:0] holdoff;
    logic [15:0] numSegments;
    logic        armOut;
    logic [15:0] segCount;
    logic [31:0] trigLen;
    logic        doneOut;

    int vectorCount = 0;
    int missCount   = 0;
    int n;

    always #5 adcClk = ~adcClk;

    trigger_engine_seg_if capIf ();

    trigger_engine_seg dut (
        .adc_clk          (adcClk),
        .reset            (reset),
        .adc_data         (adcData),
        .ext_trig_i       (extTrig),
        .ext_mask_i       (extMask),
        .ext_and_i        (extAnd),
        .source_i         (source),
        .adc_mode_i       (adcMode),
        .level_hi_i       (levelHi),
        .level_lo_i       (levelLo),
        .polarity_i       (polarity),
        .wait_i           (waitInact),
        .trigger_now_i    (triggerNow),
        .arm_i            (arm),
        .offset_i         (offset),
        .holdoff_i        (holdoff),
        .num_segments_i   (numSegments),
        .cap_if           (capIf),
        .arm_o            (armOut),
        .seg_count_o      (segCount),
        .trigger_length_o (trigLen),
        .done_o           (doneOut)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(posedge adcClk);
            #1;
        end
    endtask

    task automatic waitCapture(input int limit, output int cycles);
        cycles = 0;
        while (capIf.capture_go_o !== 1'b1 && cycles < limit) begin
            applyStimulus(1);
            cycles++;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; adcData = '0; extTrig = '0; extMask = '0; extAnd = 1'b0;
        source = 1'b0; adcMode = 2'b00; levelHi = '0; levelLo = '0; polarity = 1'b1;
        waitInact = 1'b0; triggerNow = 1'b0; arm = 1'b0; offset = '0; holdoff = '0;
        numSegments = '0; capIf.capture_done_i = 1'b0;
        applyStimulus(3);
        checkOutput("reset arm_o", armOut, 0);
        checkOutput("reset capture_go", capIf.capture_go_o, 0);
        checkOutput("reset segment_go", capIf.segment_go_o, 0);
        checkOutput("reset seg_count", segCount, 0);
        checkOutput("reset trig_len", trigLen, 0);
        checkOutput("reset done", doneOut, 0);
        reset = 1'b0;
        applyStimulus(2);

        // ADC above-hi, wait for inactive, offset 10
        source = 1'b1; adcMode = 2'b00; levelHi = 12'h800; polarity = 1'b1;
        waitInact = 1'b1; offset = 10; numSegments = 1;
        applyStimulus(2);
        arm = 1'b1;
        applyStimulus(3);
        checkOutput("t1 arm_o", armOut, 1);
        for (int i = 0; i <= 8; i++) begin
            adcData = 12'(i * 256);
            applyStimulus(1);
        end
        checkOutput("t1 no capture at hi", capIf.capture_go_o, 0);
        adcData = 12'h900;
        applyStimulus(1);
        waitCapture(40, n);
        checkOutput("t1 capture latency", n, 11);
        checkOutput("t1 segment_go", capIf.segment_go_o, 1);
        checkOutput("t1 trig_len", trigLen, 11);
        applyStimulus(1);
        checkOutput("t1 segment_go one cycle", capIf.segment_go_o, 0);
        checkOutput("t1 capture held", capIf.capture_go_o, 1);
        capIf.capture_done_i = 1'b1;
        applyStimulus(1);
        capIf.capture_done_i = 1'b0;
        checkOutput("t1 done", doneOut, 1);
        checkOutput("t1 seg_count", segCount, 1);
        checkOutput("t1 capture off", capIf.capture_go_o, 0);
        checkOutput("t1 arm_o in done", armOut, 1);
        arm = 1'b0;
        applyStimulus(1);
        checkOutput("t1 idle arm_o", armOut, 0);
        checkOutput("t1 idle done", doneOut, 0);
        checkOutput("t1 idle seg_count", segCount, 0);

        // ADC inside window, inverted polarity, offset 0
        adcMode = 2'b10; levelLo = 12'h100; levelHi = 12'h200; polarity = 1'b0;
        waitInact = 1'b0; offset = 0; adcData = 12'h150;
        applyStimulus(2);
        arm = 1'b1;
        applyStimulus(4);
        checkOutput("t2 in window", capIf.capture_go_o, 0);
        adcData = 12'h200;
        applyStimulus(3);
        checkOutput("t2 at hi edge", capIf.capture_go_o, 0);
        adcData = 12'h300;
        applyStimulus(1);
        checkOutput("t2 sample cycle", capIf.capture_go_o, 0);
        applyStimulus(1);
        checkOutput("t2 offset0 capture", capIf.capture_go_o, 1);
        checkOutput("t2 segment_go", capIf.segment_go_o, 1);
        arm = 1'b0;
        applyStimulus(1);

        // External AND of masked inputs
        source = 1'b0; polarity = 1'b1; extAnd = 1'b1; extMask = 4'b0000; extTrig = 4'b1111;
        applyStimulus(2);
        arm = 1'b1;
        applyStimulus(4);
        checkOutput("t3 empty mask", capIf.capture_go_o, 0);
        extMask = 4'b0101; extTrig = 4'b0001;
        applyStimulus(4);
        checkOutput("t3 bit0 only", capIf.capture_go_o, 0);
        extTrig = 4'b0101;
        applyStimulus(2);
        checkOutput("t3 bits0+2", capIf.capture_go_o, 1);
        arm = 1'b0; extTrig = 4'b0000;
        applyStimulus(1);

        // Three segments with holdoff 5
        extAnd = 1'b0; extMask = 4'b0001; extTrig = 4'b0001; numSegments = 3; holdoff = 5;
        applyStimulus(2);
        arm = 1'b1;
        applyStimulus(1);
        waitCapture(10, n);
        checkOutput("t4 seg1 start", n, 1);
        for (int k = 1; k <= 3; k++) begin
            checkOutput($sformatf("t4 seg%0d segment_go", k), capIf.segment_go_o, 1);
            applyStimulus(1);
            checkOutput($sformatf("t4 seg%0d pulse end", k), capIf.segment_go_o, 0);
            applyStimulus(1);
            checkOutput($sformatf("t4 seg%0d capture", k), capIf.capture_go_o, 1);
            capIf.capture_done_i = 1'b1;
            applyStimulus(1);
            capIf.capture_done_i = 1'b0;
            checkOutput($sformatf("t4 seg%0d count", k), segCount, k);
            checkOutput($sformatf("t4 seg%0d done", k), doneOut, (k == 3) ? 1 : 0);
            if (k < 3) begin
                waitCapture(20, n);
                checkOutput($sformatf("t4 gap after seg%0d", k), n, 6);
            end
        end
        capIf.capture_done_i = 1'b1;
        applyStimulus(1);
        capIf.capture_done_i = 1'b0;
        checkOutput("t4 done ignores capture_done", segCount, 3);
        arm = 1'b0;
        applyStimulus(1);
        checkOutput("t4 abort clears count", segCount, 0);

        // trigger_now with inactive trigger, offset 3
        extMask = 4'b0000; extTrig = 4'b0000; waitInact = 1'b1; offset = 3; numSegments = 1; holdoff = 0;
        applyStimulus(2);
        arm = 1'b1;
        applyStimulus(4);
        checkOutput("t5 idle trigger", capIf.capture_go_o, 0);
        triggerNow = 1'b1;
        waitCapture(20, n);
        checkOutput("t5 now latency", n, 7);
        checkOutput("t5 segment_go", capIf.segment_go_o, 1);
        checkOutput("t5 trig_len", trigLen, 0);
        triggerNow = 1'b0;

        // Abort coincident with capture_done in CAPTURE
        arm = 1'b0;
        capIf.capture_done_i = 1'b1;
        applyStimulus(1);
        capIf.capture_done_i = 1'b0;
        checkOutput("t6 arm_o", armOut, 0);
        checkOutput("t6 capture_go", capIf.capture_go_o, 0);
        checkOutput("t6 seg_count", segCount, 0);
        checkOutput("t6 done", doneOut, 0);

        // wait_i holds off while trigger already active at arm time
        extMask = 4'b0001; extTrig = 4'b0001; offset = 0;
        applyStimulus(2);
        arm = 1'b1;
        applyStimulus(5);
        checkOutput("t7 held in wait", capIf.capture_go_o, 0);
        checkOutput("t7 arm_o", armOut, 1);
        extTrig = 4'b0000;
        applyStimulus(2);
        extTrig = 4'b0001;
        applyStimulus(1);
        checkOutput("t7 trigger cycle", capIf.capture_go_o, 0);
        applyStimulus(1);
        checkOutput("t7 capture after release", capIf.capture_go_o, 1);
        arm = 1'b0;
        applyStimulus(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
